// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front end.
// The fetch entry pairs a returned instruction with the address of the instruction after it.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
    } fetch_entry_t;

    typedef enum logic {
        PH_RUN,
        PH_DRAIN
    } fetch_phase_e;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bus between the fetch queue, the instruction memory port and the IF/ID consumer.
// The master modport is the fetch queue itself; slave is its environment.
interface instr_fetch_queue_if;
    import fetch_pkg::*;

    logic               req_valid_o;
    logic [ADDR_W-1:0]  req_addr_o;
    logic               req_ready_i;
    logic               resp_valid_i;
    logic [INSTR_W-1:0] resp_data_i;
    logic               deq_valid_o;
    logic [INSTR_W-1:0] deq_instr_o;
    logic [ADDR_W-1:0]  deq_pc_plus4_o;
    logic               deq_ready_i;
    logic               redirect_i;
    logic [ADDR_W-1:0]  redirect_pc_i;
    logic               err_o;

    modport master (
        output req_valid_o, req_addr_o, deq_valid_o, deq_instr_o, deq_pc_plus4_o, err_o,
        input  req_ready_i, resp_valid_i, resp_data_i, deq_ready_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, deq_valid_o, deq_instr_o, deq_pc_plus4_o, err_o,
        output req_ready_i, resp_valid_i, resp_data_i, deq_ready_i, redirect_i, redirect_pc_i
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries with flush; head is read combinationally.
// Pointers are log2(DEPTH) bits wide so they wrap by power-of-two masking.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Prefetching fetch front end: issues sequential requests under a credit limit, buffers
// returned words with their PC+4, and flushes/drops stale responses on a redirect.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input logic                 clk_i,
    input logic                 rst_n,
    instr_fetch_queue_if.master bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  count;
    logic              err;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [PTR_W-1:0]  addr_wr;
    logic [PTR_W-1:0]  addr_rd;

    fetch_phase_e      phase;
    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              resp_ok;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Queued entries plus in-flight requests never exceed DEPTH, so a response always has room.
    assign credit_used     = {1'b0, count} + {1'b0, outstanding};
    assign bus.req_valid_o = rst_n && !bus.redirect_i && (credit_used < {1'b0, DEPTH_C});
    assign bus.req_addr_o  = fetch_pc;

    assign phase      = (drop_cnt != '0) ? PH_DRAIN : PH_RUN;
    assign issue      = bus.req_valid_o && bus.req_ready_i;
    assign resp_ok    = bus.resp_valid_i && (outstanding != '0);
    assign push       = resp_ok && !bus.redirect_i && (phase == PH_RUN);
    assign pop        = (count != '0) && bus.deq_ready_i && !bus.redirect_i;
    assign push_entry = {bus.resp_data_i, addr_q[addr_rd] + ADDR_W'(4)};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_i),
        .head      (head),
        .count     (count)
    );

    // Request addresses in issue order; every response, kept or dropped, retires one.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            addr_q[addr_wr] <= fetch_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            fetch_pc    <= align_word(RESET_PC);
            outstanding <= '0;
            drop_cnt    <= '0;
            err         <= 1'b0;
            addr_wr     <= '0;
            addr_rd     <= '0;
        end else begin
            if (issue) begin
                addr_wr <= addr_wr + PTR_W'(1);
            end
            if (resp_ok) begin
                addr_rd <= addr_rd + PTR_W'(1);
            end
            if (bus.resp_valid_i && (outstanding == '0)) begin
                err <= 1'b1;
            end
            case ({issue, resp_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: ;
            endcase
            // Every request still in flight after a redirect belongs to the old path.
            if (bus.redirect_i) begin
                fetch_pc <= align_word(bus.redirect_pc_i);
                drop_cnt <= resp_ok ? (outstanding - CNT_W'(1)) : outstanding;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (resp_ok && (phase == PH_DRAIN)) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign bus.deq_valid_o    = (count != '0);
    assign bus.deq_instr_o    = head.instr;
    assign bus.deq_pc_plus4_o = head.pc_plus4;
    assign bus.err_o          = err;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a small in-order variable-latency memory model.
`timescale 1ns/1ps
module tb_instr_fetch_queue;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    instr_fetch_queue_if bus();

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int          mem_lat   = 1;
    bit          man_mode  = 1'b0;
    bit          man_valid = 1'b0;
    logic [31:0] man_data  = '0;
    int          req_cnt   = 0;
    int unsigned cyc       = 0;
    bit          model_drove = 1'b0;
    bit          mem_hs;
    logic [31:0] mem_hs_addr;
    logic [31:0]  pend_addr [$];
    int unsigned  pend_due  [$];

    // Memory returns addr ^ 0xDEAD0000, in order, mem_lat cycles after acceptance.
    initial begin
        bus.resp_valid_i = 1'b0;
        bus.resp_data_i  = '0;
        forever begin
            @(negedge clk_i);
            mem_hs      = (bus.req_valid_o === 1'b1) && (bus.req_ready_i === 1'b1);
            mem_hs_addr = bus.req_addr_o;
            @(posedge clk_i);
            #1;
            cyc++;
            if (!rst_n) begin
                pend_addr.delete();
                pend_due.delete();
                req_cnt          = 0;
                model_drove      = 1'b0;
                bus.resp_valid_i = 1'b0;
                bus.resp_data_i  = '0;
            end else begin
                if (model_drove) begin
                    pend_addr.delete(0);
                    pend_due.delete(0);
                end
                if (mem_hs) begin
                    pend_addr.push_back(mem_hs_addr);
                    pend_due.push_back(cyc + mem_lat - 1);
                    req_cnt++;
                end
                model_drove = 1'b0;
                if (man_mode) begin
                    bus.resp_valid_i = man_valid;
                    bus.resp_data_i  = man_data;
                    man_valid        = 1'b0;
                end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                    bus.resp_valid_i = 1'b1;
                    bus.resp_data_i  = pend_addr[0] ^ 32'hDEAD_0000;
                    model_drove      = 1'b1;
                end else begin
                    bus.resp_valid_i = 1'b0;
                    bus.resp_data_i  = '0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time=%0t want <100000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic apply_reset();
        rst_n             = 1'b0;
        bus.req_ready_i   = 1'b0;
        bus.deq_ready_i   = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        man_mode          = 1'b0;
        man_valid         = 1'b0;
        repeat (2) tick();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        #1;
    endtask

    // Fill the queue, then reset mid-operation and check every reset value.
    task automatic test_reset();
        apply_reset();
        mem_lat         = 1;
        bus.req_ready_i = 1'b1;
        release_reset();
        repeat (4) tick();
        apply_reset();
        #1;
        total++; if (bus.req_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_req_valid: got %b want 0", bus.req_valid_o); end
        total++; if (bus.req_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_req_addr: got %h want 00000000", bus.req_addr_o); end
        total++; if (bus.deq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_deq_valid: got %b want 0", bus.deq_valid_o); end
        total++; if (bus.deq_instr_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_deq_instr: got %h want 00000000", bus.deq_instr_o); end
        total++; if (bus.deq_pc_plus4_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_deq_pc4: got %h want 00000000", bus.deq_pc_plus4_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", bus.err_o); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_addr;
        logic [31:0] exp_pc4;
        logic [31:0] exp_instr;
        apply_reset();
        mem_lat         = 1;
        bus.req_ready_i = 1'b1;
        bus.deq_ready_i = 1'b1;
        release_reset();
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin
                tick();
                #1;
            end
            exp_addr = 32'(4 * k);
            total++;
            if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== exp_addr) begin
                bad++;
                $display("[TB] FAIL stream_req k=%0d: got valid=%b addr=%h want valid=1 addr=%h", k, bus.req_valid_o, bus.req_addr_o, exp_addr);
            end
            if (k < 2) begin
                total++;
                if (bus.deq_valid_o !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL stream_early_deq k=%0d: got %b want 0", k, bus.deq_valid_o);
                end
            end else begin
                exp_pc4   = 32'(4 * (k - 1));
                exp_instr = 32'hDEAD_0000 ^ 32'(4 * (k - 2));
                total++;
                if (bus.deq_valid_o !== 1'b1 || bus.deq_pc_plus4_o !== exp_pc4 || bus.deq_instr_o !== exp_instr) begin
                    bad++;
                    $display("[TB] FAIL stream_deq k=%0d: got v=%b pc4=%h instr=%h want v=1 pc4=%h instr=%h", k, bus.deq_valid_o, bus.deq_pc_plus4_o, bus.deq_instr_o, exp_pc4, exp_instr);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        mem_lat         = 1;
        bus.req_ready_i = 1'b1;
        bus.deq_ready_i = 1'b0;
        release_reset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            if (k >= 4) begin
                total++;
                if (bus.req_valid_o !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL bp_req_stall k=%0d: got %b want 0", k, bus.req_valid_o);
                end
            end
        end
        total++; if (req_cnt != 4) begin bad++; $display("[TB] FAIL bp_req_count: got %0d want 4", req_cnt); end
        total++; if (bus.deq_valid_o !== 1'b1 || bus.deq_pc_plus4_o !== 32'h4) begin bad++; $display("[TB] FAIL bp_head: got v=%b pc4=%h want v=1 pc4=00000004", bus.deq_valid_o, bus.deq_pc_plus4_o); end
        bus.deq_ready_i = 1'b1;
        #1;
        total++; if (bus.req_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_same_cycle: got %b want 0", bus.req_valid_o); end
        tick();
        #1;
        total++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 32'h10) begin bad++; $display("[TB] FAIL bp_resume: got v=%b addr=%h want v=1 addr=00000010", bus.req_valid_o, bus.req_addr_o); end
        for (int j = 1; j <= 4; j++) begin
            if (j > 1) begin
                tick();
                #1;
            end
            total++;
            if (bus.deq_valid_o !== 1'b1 || bus.deq_pc_plus4_o !== 32'(4 * (j + 1))) begin
                bad++;
                $display("[TB] FAIL bp_drain j=%0d: got v=%b pc4=%h want v=1 pc4=%h", j, bus.deq_valid_o, bus.deq_pc_plus4_o, 32'(4 * (j + 1)));
            end
        end
    endtask

    task automatic test_redirect_drain();
        int n;
        apply_reset();
        mem_lat         = 3;
        bus.req_ready_i = 1'b1;
        bus.deq_ready_i = 1'b1;
        release_reset();
        repeat (3) tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0103;
        #1;
        total++; if (bus.req_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_no_req: got %b want 0", bus.req_valid_o); end
        tick();
        bus.redirect_i = 1'b0;
        #1;
        total++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 32'h100) begin bad++; $display("[TB] FAIL rd_new_req: got v=%b addr=%h want v=1 addr=00000100", bus.req_valid_o, bus.req_addr_o); end
        total++; if (bus.deq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_flushed: got %b want 0", bus.deq_valid_o); end
        n = 0;
        while (bus.deq_valid_o !== 1'b1 && n < 12) begin
            tick();
            #1;
            n++;
        end
        total++;
        if (bus.deq_valid_o !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rd_timeout: got deq_valid=%b after %0d cycles want 1", bus.deq_valid_o, n);
        end else begin
            total++; if (n != 4) begin bad++; $display("[TB] FAIL rd_latency: got %0d cycles want 4", n); end
            total++; if (bus.deq_pc_plus4_o !== 32'h104 || bus.deq_instr_o !== 32'hDEAD_0100) begin bad++; $display("[TB] FAIL rd_first: got pc4=%h instr=%h want pc4=00000104 instr=dead0100", bus.deq_pc_plus4_o, bus.deq_instr_o); end
            tick();
            #1;
            total++; if (bus.deq_valid_o !== 1'b1 || bus.deq_pc_plus4_o !== 32'h108 || bus.deq_instr_o !== 32'hDEAD_0104) begin bad++; $display("[TB] FAIL rd_second: got v=%b pc4=%h instr=%h want v=1 pc4=00000108 instr=dead0104", bus.deq_valid_o, bus.deq_pc_plus4_o, bus.deq_instr_o); end
        end
    endtask

    task automatic test_redirect_coincident();
        apply_reset();
        mem_lat         = 1;
        bus.req_ready_i = 1'b1;
        bus.deq_ready_i = 1'b1;
        release_reset();
        repeat (4) tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0200;
        #1;
        total++; if (bus.deq_valid_o !== 1'b1) begin bad++; $display("[TB] FAIL rc_pre_head: got %b want 1", bus.deq_valid_o); end
        tick();
        bus.redirect_i = 1'b0;
        #1;
        total++; if (bus.deq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rc_count0: got %b want 0", bus.deq_valid_o); end
        total++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 32'h200) begin bad++; $display("[TB] FAIL rc_new_req: got v=%b addr=%h want v=1 addr=00000200", bus.req_valid_o, bus.req_addr_o); end
        tick();
        #1;
        total++; if (bus.deq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rc_no_stale: got %b want 0", bus.deq_valid_o); end
        tick();
        #1;
        total++; if (bus.deq_valid_o !== 1'b1 || bus.deq_pc_plus4_o !== 32'h204 || bus.deq_instr_o !== 32'hDEAD_0200) begin bad++; $display("[TB] FAIL rc_first: got v=%b pc4=%h instr=%h want v=1 pc4=00000204 instr=dead0200", bus.deq_valid_o, bus.deq_pc_plus4_o, bus.deq_instr_o); end
    endtask

    task automatic test_wrap();
        apply_reset();
        mem_lat         = 1;
        bus.req_ready_i = 1'b1;
        bus.deq_ready_i = 1'b1;
        release_reset();
        repeat (2) tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        bus.redirect_i = 1'b0;
        #1;
        total++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_top: got v=%b addr=%h want v=1 addr=fffffffc", bus.req_valid_o, bus.req_addr_o); end
        tick();
        #1;
        total++; if (bus.req_valid_o !== 1'b1 || bus.req_addr_o !== 32'h0) begin bad++; $display("[TB] FAIL wrap_next: got v=%b addr=%h want v=1 addr=00000000", bus.req_valid_o, bus.req_addr_o); end
        tick();
        #1;
        total++; if (bus.deq_valid_o !== 1'b1 || bus.deq_pc_plus4_o !== 32'h0 || bus.deq_instr_o !== 32'h2152_FFFC) begin bad++; $display("[TB] FAIL wrap_pc4: got v=%b pc4=%h instr=%h want v=1 pc4=00000000 instr=2152fffc", bus.deq_valid_o, bus.deq_pc_plus4_o, bus.deq_instr_o); end
        tick();
        #1;
        total++; if (bus.deq_valid_o !== 1'b1 || bus.deq_pc_plus4_o !== 32'h4 || bus.deq_instr_o !== 32'hDEAD_0000) begin bad++; $display("[TB] FAIL wrap_after: got v=%b pc4=%h instr=%h want v=1 pc4=00000004 instr=dead0000", bus.deq_valid_o, bus.deq_pc_plus4_o, bus.deq_instr_o); end
    endtask

    task automatic test_error();
        apply_reset();
        bus.req_ready_i = 1'b0;
        bus.deq_ready_i = 1'b0;
        release_reset();
        tick();
        #1;
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL err_idle: got %b want 0", bus.err_o); end
        man_mode  = 1'b1;
        man_data  = 32'h1234_5678;
        man_valid = 1'b1;
        tick();
        #1;
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL err_early: got %b want 0", bus.err_o); end
        tick();
        #1;
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("[TB] FAIL err_set: got %b want 1", bus.err_o); end
        total++; if (bus.deq_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL err_queue: got deq_valid=%b want 0", bus.deq_valid_o); end
        repeat (3) tick();
        #1;
        total++; if (bus.err_o !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky: got %b want 1", bus.err_o); end
        rst_n = 1'b0;
        tick();
        #1;
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("[TB] FAIL err_clear: got %b want 0", bus.err_o); end
        man_mode = 1'b0;
    endtask

    initial begin
        bus.req_ready_i   = 1'b0;
        bus.deq_ready_i   = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_coincident();
        test_wrap();
        test_error();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
